// File: rtl/aux_uart_bridge_pkg.sv
// Purpose: register map and bit positions shared by the aux UART bridge files.
// Latency: n/a, constants only.
// Backpressure: n/a.
package aux_uart_bridge_pkg;

  // Register offsets within the 4-byte window.
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RXCNT  = 2'd3;

  // STATUS bit positions.
  localparam int unsigned ST_RX_NEMPTY = 0;
  localparam int unsigned ST_TX_NFULL  = 1;
  localparam int unsigned ST_RX_OVF    = 2;
  localparam int unsigned ST_TX_EMPTY  = 3;
  localparam int unsigned ST_TX_OVF    = 4;

  // CTRL bit positions. The two clear bits are write-only strobes.
  localparam int unsigned CTRL_RX_IE      = 0;
  localparam int unsigned CTRL_TX_IE      = 1;
  localparam int unsigned CTRL_RX_OVF_CLR = 6;
  localparam int unsigned CTRL_TX_OVF_CLR = 7;

endpackage

// File: rtl/aux_sync_fifo.sv
// Purpose: single-clock first-word-fall-through FIFO with full/empty/count.
// Latency: a push at edge N is visible at head_dat in cycle N+1.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   push, push_dat      write request and data
//   pop                 read request (ignored when empty)
//   head_dat            current head entry (undefined content when empty)
//   full, empty, count  occupancy flags, count ranges 0..2**DEPTH_LOG2
module aux_sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_dat,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_dat,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned        DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Emptiness is judged before the push, so push+pop on an empty FIFO only pushes.
  // A full FIFO can take a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is only meaningful while not empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);

endmodule

// File: rtl/aux_uart_bridge.sv
// Purpose: aux-bus peripheral buffering bytes between the core and a UART AXI-stream pair.
// Latency: s_axis byte at edge N readable in cycle N+1; DATA write at edge N drives m_axis in N+1.
// Backpressure: none on s_axis (overflow drops and flags rx_ovf); TX drops on full and flags tx_ovf.
//
// Optional feature: define AUX_UART_BRIDGE_IRQ_EN to enable the registered interrupt
// and the CTRL interrupt-enable bits; otherwise irq_o is 0 and CTRL bits 1:0 read 0.
//
// Ports:
//   clk_i, reset_i             clock, synchronous active-high reset
//   aux_adr_i/dat_i/we_i/re_i  core aux bus request
//   aux_dat_o, aux_dat_oe_o    combinational read data and tristate enable
//   s_axis_*                   bytes received by the UART
//   m_axis_*                   bytes to transmit, first-word fall-through
//   irq_o                      interrupt to core int0
module aux_uart_bridge
  import aux_uart_bridge_pkg::*;
#(
  parameter int unsigned                AUX_ADDR_WIDTH  = 16,
  parameter int unsigned                AUX_DATA_WIDTH  = 8,
  parameter logic [AUX_ADDR_WIDTH-1:0]  BASE_ADDR       = 16'hFF00,
  parameter int unsigned                FIFO_DEPTH_LOG2 = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [AUX_ADDR_WIDTH-1:0] aux_adr_i,
  input  logic [AUX_DATA_WIDTH-1:0] aux_dat_i,
  output logic [AUX_DATA_WIDTH-1:0] aux_dat_o,
  output logic                      aux_dat_oe_o,
  input  logic                      aux_we_i,
  input  logic                      aux_re_i,
  input  logic [AUX_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [AUX_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      irq_o
);

  localparam int unsigned CW = FIFO_DEPTH_LOG2 + 1;

  logic                      sel;
  logic [1:0]                offset;
  logic                      re_q;
  logic                      we_q;
  logic                      rd_edge;
  logic                      wr_edge;

  logic                      rx_push;
  logic                      rx_pop;
  logic [AUX_DATA_WIDTH-1:0] rx_head;
  logic                      rx_full;
  logic                      rx_empty;
  logic [CW-1:0]             rx_count;

  logic                      tx_push;
  logic                      tx_pop;
  logic [AUX_DATA_WIDTH-1:0] tx_head;
  logic                      tx_full;
  logic                      tx_empty;
  logic [CW-1:0]             tx_count;
  logic [CW-1:0]             unused_tx_count;

  logic                      ctrl_wr;
  logic                      rx_ovf;
  logic                      tx_ovf;
  logic                      rx_ie;
  logic                      tx_ie;

  logic [AUX_DATA_WIDTH-1:0] status_val;
  logic [AUX_DATA_WIDTH-1:0] ctrl_val;
  logic [AUX_DATA_WIDTH-1:0] rxcnt_val;

  // ------------------------------------------------------------------
  // Decode and access edge detection
  // ------------------------------------------------------------------
  assign sel    = (aux_adr_i[AUX_ADDR_WIDTH-1:2] == BASE_ADDR[AUX_ADDR_WIDTH-1:2]);
  assign offset = aux_adr_i[1:0];

  // A strobe held over several cycles acts once. A read overlapping a write is dropped.
  assign wr_edge = sel & aux_we_i & ~we_q;
  assign rd_edge = sel & aux_re_i & ~re_q & ~aux_we_i;

  assign rx_pop  = rd_edge & (offset == REG_DATA) & ~rx_empty;
  assign tx_push = wr_edge & (offset == REG_DATA);
  assign ctrl_wr = wr_edge & (offset == REG_CTRL);

  assign rx_push = s_axis_tvalid & ~reset_i;
  assign tx_pop  = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      re_q <= 1'b0;
      we_q <= 1'b0;
    end else begin
      re_q <= aux_re_i;
      we_q <= aux_we_i;
    end
  end

  // ------------------------------------------------------------------
  // FIFOs
  // ------------------------------------------------------------------
  aux_sync_fifo #(
    .WIDTH      (AUX_DATA_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_rx_fifo (
    .clk      (clk_i),
    .reset    (reset_i),
    .push     (rx_push),
    .push_dat (s_axis_tdata),
    .pop      (rx_pop),
    .head_dat (rx_head),
    .full     (rx_full),
    .empty    (rx_empty),
    .count    (rx_count)
  );

  aux_sync_fifo #(
    .WIDTH      (AUX_DATA_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_tx_fifo (
    .clk      (clk_i),
    .reset    (reset_i),
    .push     (tx_push),
    .push_dat (aux_dat_i),
    .pop      (tx_pop),
    .head_dat (tx_head),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_count)
  );

  // TX occupancy is not exposed through the register map.
  assign unused_tx_count = tx_count;

  // The UART receiver cannot be stalled, so ready only drops during reset.
  assign s_axis_tready = ~reset_i;
  assign m_axis_tvalid = ~tx_empty;
  assign m_axis_tdata  = tx_empty ? '0 : tx_head;

  // ------------------------------------------------------------------
  // Sticky overflow flags. A new overflow in the same cycle as a clear wins.
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_ovf <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      if (rx_push & rx_full & ~rx_pop) begin
        rx_ovf <= 1'b1;
      end else if (ctrl_wr & aux_dat_i[CTRL_RX_OVF_CLR]) begin
        rx_ovf <= 1'b0;
      end

      if (tx_push & tx_full & ~tx_pop) begin
        tx_ovf <= 1'b1;
      end else if (ctrl_wr & aux_dat_i[CTRL_TX_OVF_CLR]) begin
        tx_ovf <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Interrupt enables and interrupt line
  // ------------------------------------------------------------------
`ifdef AUX_UART_BRIDGE_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        rx_ie <= aux_dat_i[CTRL_RX_IE];
        tx_ie <= aux_dat_i[CTRL_TX_IE];
      end
      irq_q <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty) | rx_ovf;
    end
  end

  assign irq_o = irq_q;
`else
  assign rx_ie = 1'b0;
  assign tx_ie = 1'b0;
  assign irq_o = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Read mux
  // ------------------------------------------------------------------
  always_comb begin
    status_val               = '0;
    status_val[ST_RX_NEMPTY] = ~rx_empty;
    status_val[ST_TX_NFULL]  = ~tx_full;
    status_val[ST_RX_OVF]    = rx_ovf;
    status_val[ST_TX_EMPTY]  = tx_empty;
    status_val[ST_TX_OVF]    = tx_ovf;

    ctrl_val                 = '0;
    ctrl_val[CTRL_RX_IE]     = rx_ie;
    ctrl_val[CTRL_TX_IE]     = tx_ie;

    rxcnt_val                = '0;
    rxcnt_val[CW-1:0]        = rx_count;
  end

  always_comb begin
    aux_dat_o = '0;
    if (sel && !reset_i) begin
      case (offset)
        REG_DATA:   aux_dat_o = rx_empty ? '0 : rx_head;
        REG_STATUS: aux_dat_o = status_val;
        REG_CTRL:   aux_dat_o = ctrl_val;
        REG_RXCNT:  aux_dat_o = rxcnt_val;
        default:    aux_dat_o = '0;
      endcase
    end
  end

  assign aux_dat_oe_o = sel & aux_re_i & ~aux_we_i & ~reset_i;

endmodule

// File: tb/tb_aux_uart_bridge.sv
// Purpose: directed self-checking bench for aux_uart_bridge with RX/TX scoreboards.
// Latency: n/a.
// Backpressure: m_axis_tready is driven by the stimulus sequence.
module tb_aux_uart_bridge;

`ifdef AUX_UART_BRIDGE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  localparam logic [15:0] A_DATA   = 16'hFF00;
  localparam logic [15:0] A_STATUS = 16'hFF01;
  localparam logic [15:0] A_CTRL   = 16'hFF02;
  localparam logic [15:0] A_RXCNT  = 16'hFF03;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] aux_adr_i;
  logic [7:0]  aux_dat_i;
  logic [7:0]  aux_dat_o;
  logic        aux_dat_oe_o;
  logic        aux_we_i;
  logic        aux_re_i;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        irq_o;

  always #5 clk = ~clk;

  aux_uart_bridge dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .aux_adr_i     (aux_adr_i),
    .aux_dat_i     (aux_dat_i),
    .aux_dat_o     (aux_dat_o),
    .aux_dat_oe_o  (aux_dat_oe_o),
    .aux_we_i      (aux_we_i),
    .aux_re_i      (aux_re_i),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .irq_o         (irq_o)
  );

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit         rx_ovf_m = 1'b0;
  bit         tx_ovf_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    return {3'b000, tx_ovf_m, (tx_q.size() == 0), rx_ovf_m,
            (tx_q.size() < 16), (rx_q.size() != 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One read access: sample the combinational data, then let the strobe edge act.
  task automatic aux_read(input logic [15:0] a, output logic [7:0] d);
    aux_adr_i = a;
    aux_re_i  = 1'b1;
    #1;
    d = aux_dat_o;
    check("read_oe", aux_dat_oe_o, 1);
    @(posedge clk);
    #1;
    aux_re_i = 1'b0;
    tick();
  endtask

  task automatic read_data_check(input string tag);
    logic [7:0] d;
    logic [7:0] e;
    aux_read(A_DATA, d);
    e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
    check(tag, d, e);
  endtask

  task automatic read_reg_check(input string tag, input logic [15:0] a, input logic [7:0] e);
    logic [7:0] d;
    aux_read(a, d);
    check(tag, d, e);
  endtask

  // Writes are issued with m_axis_tready low, so the TX model never drains here.
  task automatic aux_write(input logic [15:0] a, input logic [7:0] d);
    aux_adr_i = a;
    aux_dat_i = d;
    aux_we_i  = 1'b1;
    tick();
    aux_we_i  = 1'b0;
    tick();
    if (a == A_DATA) begin
      if (tx_q.size() < 16) tx_q.push_back(d);
      else tx_ovf_m = 1'b1;
    end else if (a == A_CTRL) begin
      if (d[6]) rx_ovf_m = 1'b0;
      if (d[7]) tx_ovf_m = 1'b0;
    end
  endtask

  task automatic rx_push(input logic [7:0] b);
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    if (rx_q.size() < 16) rx_q.push_back(b);
    else rx_ovf_m = 1'b1;
  endtask

  // Drain TX with tready high; returns the number of cycles used (bounded).
  task automatic tx_drain(input int limit, output int cyc);
    m_axis_tready = 1'b1;
    cyc = 0;
    while (tx_q.size() > 0 && cyc < limit) begin
      if (m_axis_tvalid) check("tx_dat", m_axis_tdata, tx_q.pop_front());
      tick();
      cyc++;
    end
    m_axis_tready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         cyc;

    reset_i       = 1'b1;
    aux_adr_i     = 16'h0000;
    aux_dat_i     = 8'h00;
    aux_we_i      = 1'b0;
    aux_re_i      = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) tick();

    // Reset outputs.
    aux_adr_i = A_STATUS;
    check("rst_tready", s_axis_tready, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 8'h00);
    check("rst_irq", irq_o, 0);
    check("rst_dat", aux_dat_o, 8'h00);
    check("rst_oe", aux_dat_oe_o, 0);
    reset_i = 1'b0;
    #1;
    check("tready_after_rst", s_axis_tready, 1);

    // 1. Idle register values, empty DATA read does not pop.
    read_reg_check("status_idle", A_STATUS, 8'h0A);
    read_reg_check("rxcnt_idle", A_RXCNT, 8'h00);
    read_data_check("data_empty");
    read_reg_check("rxcnt_after_empty_read", A_RXCNT, 8'h00);

    // Unselected address drives 0 with no output enable.
    aux_adr_i = 16'h1234;
    aux_re_i  = 1'b1;
    #1;
    check("unsel_dat", aux_dat_o, 8'h00);
    check("unsel_oe", aux_dat_oe_o, 0);
    aux_re_i = 1'b0;
    tick();

    // 2. Three bytes in, three out; first is readable the cycle after it lands.
    rx_push(8'h41);
    read_reg_check("rx_latency_status", A_STATUS, exp_status());
    rx_push(8'h42);
    rx_push(8'h43);
    read_reg_check("rxcnt_3", A_RXCNT, 8'd3);
    repeat (3) read_data_check("rx_data_abc");
    read_reg_check("rxcnt_0", A_RXCNT, 8'd0);

    // Held read strobe pops exactly one byte.
    rx_push(8'h61);
    rx_push(8'h62);
    aux_adr_i = A_DATA;
    aux_re_i  = 1'b1;
    #1;
    check("held_read_dat", aux_dat_o, rx_q[0]);
    repeat (3) tick();
    aux_re_i = 1'b0;
    tick();
    void'(rx_q.pop_front());
    read_reg_check("held_read_rxcnt", A_RXCNT, 8'(rx_q.size()));
    read_data_check("held_read_next");

    // Empty FIFO with simultaneous push and read: pop ignored, count becomes 1.
    aux_adr_i     = A_DATA;
    aux_re_i      = 1'b1;
    s_axis_tdata  = 8'h33;
    s_axis_tvalid = 1'b1;
    #1;
    check("empty_pushpop_dat", aux_dat_o, 8'h00);
    tick();
    aux_re_i      = 1'b0;
    s_axis_tvalid = 1'b0;
    tick();
    rx_q.push_back(8'h33);
    read_reg_check("empty_pushpop_rxcnt", A_RXCNT, 8'd1);
    read_data_check("empty_pushpop_data");

    // 3. RX overflow: 17 bytes into 16 entries.
    for (int i = 0; i < 17; i++) rx_push(8'(i));
    read_reg_check("rx_full_cnt", A_RXCNT, 8'd16);
    read_reg_check("rx_ovf_status", A_STATUS, exp_status());
    for (int i = 0; i < 16; i++) read_data_check("rx_ovf_data");
    aux_write(A_CTRL, 8'h40);
    read_reg_check("rx_ovf_clear", A_STATUS, exp_status());

    // 4. TX path with backpressure, first write checked for one-cycle latency.
    aux_adr_i = A_DATA;
    aux_dat_i = 8'h55;
    aux_we_i  = 1'b1;
    tick();
    tx_q.push_back(8'h55);
    check("tx_latency_vld", m_axis_tvalid, 1);
    check("tx_head", m_axis_tdata, 8'h55);
    aux_we_i = 1'b0;
    tick();
    aux_write(A_DATA, 8'hAA);
    check("tx_still_head", m_axis_tdata, 8'h55);
    read_reg_check("tx_busy_status", A_STATUS, exp_status());
    tx_drain(20, cyc);
    check("tx_drain_cycles", cyc, 2);
    check("tx_idle_vld", m_axis_tvalid, 0);
    read_reg_check("tx_empty_status", A_STATUS, exp_status());

    // TX overflow: 17 writes into 16 entries, then drain and clear.
    for (int i = 0; i < 17; i++) aux_write(A_DATA, 8'(8'hC0 + i));
    read_reg_check("tx_ovf_status", A_STATUS, exp_status());
    tx_drain(40, cyc);
    check("tx_ovf_drain_cycles", cyc, 16);
    aux_write(A_CTRL, 8'h80);
    read_reg_check("tx_ovf_clear", A_STATUS, exp_status());

    // 5. Full RX with simultaneous push and pop.
    for (int i = 0; i < 16; i++) rx_push(8'(8'h80 + i));
    aux_adr_i     = A_DATA;
    aux_re_i      = 1'b1;
    s_axis_tdata  = 8'h90;
    s_axis_tvalid = 1'b1;
    #1;
    check("full_pushpop_dat", aux_dat_o, rx_q.pop_front());
    tick();
    aux_re_i      = 1'b0;
    s_axis_tvalid = 1'b0;
    tick();
    rx_q.push_back(8'h90);
    read_reg_check("full_pushpop_cnt", A_RXCNT, 8'd16);
    read_reg_check("full_pushpop_status", A_STATUS, exp_status());
    for (int i = 0; i < 16; i++) read_data_check("full_pushpop_drain");

    // 6. Interrupt on RX not-empty.
    aux_write(A_CTRL, 8'h01);
    read_reg_check("ctrl_readback", A_CTRL, IRQ_EN ? 8'h01 : 8'h00);
    check("irq_idle", irq_o, 0);
    rx_push(8'h7E);
    check("irq_land_cycle", irq_o, 0);
    tick();
    check("irq_set", irq_o, IRQ_EN);
    read_data_check("irq_data");
    check("irq_cleared", irq_o, 0);
    aux_write(A_CTRL, 8'h00);

    // Reset mid-transfer discards everything.
    rx_push(8'h11);
    rx_push(8'h22);
    aux_write(A_DATA, 8'h99);
    reset_i = 1'b1;
    tick();
    check("midrst_tready", s_axis_tready, 0);
    tick();
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_tdata", m_axis_tdata, 8'h00);
    reset_i = 1'b0;
    rx_q.delete();
    tx_q.delete();
    rx_ovf_m = 1'b0;
    tx_ovf_m = 1'b0;
    read_reg_check("midrst_rxcnt", A_RXCNT, 8'h00);
    read_reg_check("midrst_status", A_STATUS, 8'h0A);
    check("midrst_irq", irq_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/aux_uart_bridge.md
Name: aux_uart_bridge

Overview:
Memory-mapped peripheral on the PIC core's aux bus. It gives firmware a buffered byte-stream path to and from a UART's AXI-stream interface.
- RX path: bytes from the UART output stream are buffered in an RX FIFO and read by the core through the aux bus.
- TX path: aux-bus writes are buffered in a TX FIFO and drained into the UART input stream.
- An optional interrupt line drives the core's int0 input.
- Sits between the core's aux bus and the UART AXI-stream ports, directly downstream of the core's aux bus.

Parameters:
BASE_ADDR, 16'hFF00, aux address of register 0; registers occupy BASE_ADDR..BASE_ADDR+3.
FIFO_DEPTH_LOG2, 4, log2 of RX and TX FIFO depth (default 16 entries each).
AUX_ADDR_WIDTH, 16, aux address width.
AUX_DATA_WIDTH, 8, aux data and stream data width.

Ports:
clk_i  in  1  clock; all logic on rising edge.
reset_i  in  1  synchronous, active-high reset.
aux_adr_i  in  AUX_ADDR_WIDTH  aux address from core.
aux_dat_i  in  AUX_DATA_WIDTH  write data from core.
aux_dat_o  out  AUX_DATA_WIDTH  read data to core (combinational).
aux_dat_oe_o  out  1  high when the core reads a decoded register; the top level builds the tristate from it.
aux_we_i  in  1  write strobe.
aux_re_i  in  1  read strobe.
s_axis_tdata  in  8  RX byte from UART.
s_axis_tvalid  in  1  RX byte valid.
s_axis_tready  out  1  RX ready.
m_axis_tdata  out  8  TX byte to UART.
m_axis_tvalid  out  1  TX byte valid.
m_axis_tready  in  1  UART ready.
irq_o  out  1  interrupt to core int0.

Behaviour:
- Address decode: sel = aux_adr_i[AW-1:2] == BASE_ADDR[AW-1:2]; offset = aux_adr_i[1:0].
- Register map:
  - 0 DATA: read pops the RX head; write pushes the TX FIFO.
  - 1 STATUS (read-only): bit0 rx_nempty, bit1 tx_nfull, bit2 rx_ovf, bit3 tx_empty, bit4 tx_ovf, bits7:5 = 0.
  - 2 CTRL (R/W): bit0 rx_ie, bit1 tx_ie. Writing 1 to bit6 clears rx_ovf; writing 1 to bit7 clears tx_ovf. Bits 7:6 read 0.
  - 3 RXCNT (read-only): RX occupancy, zero-extended.
- Read path:
  - aux_dat_o is combinational from the current state.
  - aux_dat_oe_o = sel & aux_re_i & ~aux_we_i.
  - When not selected, aux_dat_o = 0.
  - DATA read while RX is empty returns 8'h00 and does not pop.
- Pop/push edge detection:
  - An RX pop occurs once per read access, on the clock edge where aux_re_i & ~re_q & sel & offset==0 & rx_nempty.
  - re_q is aux_re_i registered, so a read strobe held for several cycles pops exactly one byte.
  - Writes use the same edge rule with aux_we_i / we_q.
  - Simultaneous re and we: the write wins and the read is ignored.
- RX FIFO:
  - s_axis_tready = ~reset_i (always accepts). The UART rxd has no flow control, so back-pressure is never applied.
  - Push when s_axis_tvalid.
  - If full and no pop in the same cycle: the byte is dropped and rx_ovf is set (sticky).
  - If full with a simultaneous pop: push and pop both occur, count unchanged, no overflow.
  - Empty with a simultaneous push and pop: the pop is ignored because rx_nempty is evaluated before the push. Count becomes 1.
- TX FIFO:
  - m_axis_tvalid = tx not empty; m_axis_tdata = TX head (first-word fall-through).
  - Pop on m_axis_tvalid & m_axis_tready.
  - A DATA write when full with no pop in the same cycle drops the byte and sets tx_ovf.
  - A write when full with a same-cycle pop is accepted.
- Latency:
  - A byte accepted on s_axis at edge N is visible in DATA/STATUS/RXCNT in cycle N+1.
  - A DATA write at edge N gives m_axis_tvalid in cycle N+1.
- Counters: pointers are FIFO_DEPTH_LOG2 bits and wrap modulo the depth. Counts are FIFO_DEPTH_LOG2+1 bits, range 0..DEPTH.
- Reset (synchronous): both FIFOs are emptied, rx_ovf, tx_ovf, rx_ie, tx_ie, re_q and we_q cleared. Output values:
  - aux_dat_o = 0, aux_dat_oe_o = 0
  - m_axis_tvalid = 0, m_axis_tdata = 0
  - s_axis_tready = 0 while reset_i is high
  - irq_o = 0
- Reset mid-transfer: in-flight bytes are discarded with no partial state.

Optional Feature:
Macro AUX_UART_BRIDGE_IRQ_EN.
- Defined: irq_o is registered as (rx_ie & rx_nempty) | (tx_ie & tx_empty) | rx_ovf, with one cycle of latency from the state change.
- Undefined:
  - irq_o is tied to 0.
  - CTRL bits 1:0 read 0.
  - Writes to CTRL bits 1:0 are ignored; ovf clear bits still work.

Decomposition:
- Package aux_uart_bridge_pkg holds:
  - register offset constants: REG_DATA=2'd0, REG_STATUS=2'd1, REG_CTRL=2'd2, REG_RXCNT=2'd3;
  - STATUS bit index constants;
  - CTRL bit index constants.
- One sub-module, aux_sync_fifo (parameterised width and depth log2, first-word fall-through, full/empty/count outputs), instantiated twice: RX and TX.

Test Plan:
1. Reset, then read STATUS at 16'hFF01 -> 8'h0A (tx_nfull, tx_empty); RXCNT -> 8'h00; DATA -> 8'h00, and RXCNT stays 0.
2. Push 0x41, 0x42, 0x43 on s_axis. RXCNT -> 3. Three DATA reads -> 0x41, 0x42, 0x43, then RXCNT -> 0. A read strobe held 3 cycles pops only one byte.
3. Push 17 bytes 0x00..0x10 with no reads -> RXCNT = 16, STATUS bit2 = 1, reads return 0x00..0x0F. Write CTRL 8'h40 -> bit2 clears.
4. Write 0x55, 0xAA to DATA with m_axis_tready low -> m_axis_tvalid = 1, tdata = 0x55, STATUS bit3 = 0. Raise tready -> 0x55 then 0xAA transfer on consecutive cycles, then STATUS bit3 = 1.
5. With the RX FIFO at 16 entries, a same-cycle s_axis push and DATA pop -> count stays 16, rx_ovf stays 0, head advances by one.
6. With AUX_UART_BRIDGE_IRQ_EN: write CTRL 8'h01, push 0x7E -> irq_o = 1 one cycle after the byte lands; a DATA read returns 0x7E, and irq_o = 0 one cycle after the pop. Without the macro, irq_o stays 0 throughout.
